avmm_onchip_ram: RTL and testbench

- Parametrised Avalon-MM slave on-chip RAM. Successor to the fixed 32-bit/4093-word single-port memory.
- Adds configurable width, depth and read latency, an explicit read strobe with a readdatavalid pipeline, waitrequest, and a post-reset hardware clear engine.
- Out-of-range address handling for non-power-of-2 depths.
- Sits on the system interconnect as a pipelined read-latency slave.

---
 rtl/avmm_onchip_ram_pkg.sv | 20 ++
 rtl/avmm_onchip_ram_core.sv | 43 ++++
 rtl/avmm_onchip_ram.sv | 155 +++++++++++++++
 tb/tb_avmm_onchip_ram.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_onchip_ram_pkg.sv
// Shared types and elaboration helpers for the Avalon-MM on-chip RAM.
package avmm_onchip_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int addr_w, input int read_latency);
    return (data_w % 8 == 0) && (data_w >= 8) && (data_w <= 128) &&
           (depth >= 2) && (longint'(depth) <= (longint'(1) << addr_w)) &&
           (read_latency == 1 || read_latency == 2);
  endfunction

endpackage

// File: rtl/avmm_onchip_ram_core.sv
// Single-port byte-enabled RAM with registered read and a clock enable.
module avmm_onchip_ram_core
  import avmm_onchip_ram_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 4093,
  parameter int    MEM_AW         = 12,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = "",
  localparam int   BE_W           = be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              clken,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Preloading from INIT_FILE is handled by the device memory-initialisation flow.
  if (CLEAR_ON_RESET && INIT_FILE != "") begin : g_init_ignored
    $warning("avmm_onchip_ram_core: INIT_FILE contents are overwritten by the post-reset clear");
  end

  // NOTE: the array has no reset so it maps onto block RAM; rdata_q is
  // qualified by the valid pipeline and needs none either.
  always_ff @(posedge clk) begin
    if (clken) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      // NOTE: non-blocking assignments keep this a read-before-write port.
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avmm_onchip_ram.sv
// Avalon-MM pipelined-read slave RAM with post-reset clear engine.
module avmm_onchip_ram
  import avmm_onchip_ram_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 4093,
  parameter int    ADDR_W         = 12,
  parameter int    READ_LATENCY   = 1,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = "",
  localparam int   BE_W           = be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   byteenable,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clken,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic              init_done
);

  localparam int                MEM_AW    = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);

  if (!params_ok(DATA_W, DEPTH, ADDR_W, READ_LATENCY)) begin : g_param_err
    $error("avmm_onchip_ram: illegal DATA_W / DEPTH / ADDR_W / READ_LATENCY combination");
  end

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   clr_addr_q, clr_addr_d;
  logic                rd1_q, rd1_d, rng1_q, rng1_d;
  logic [DATA_W-1:0]   rdata_hold_q, rdata_hold_d;

  logic                ready, accept, wr_acc, rd_acc, in_range;
  logic                ram_we;
  logic [BE_W-1:0]     ram_be;
  logic [MEM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata, data1;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;

  assign ready    = (state_q == ST_READY);
  assign in_range = ({1'b0, address} < DEPTH_X);
  assign accept   = ready & chipselect & (read | write) & clken;
  // A simultaneous read and write is served as a write only.
  assign wr_acc   = accept & write;
  assign rd_acc   = accept & read & ~write;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    waitrequest = 1'b1;
    init_done   = 1'b0;
    ram_we      = 1'b0;
    ram_be      = '0;
    ram_addr    = address[MEM_AW-1:0];
    ram_wdata   = writedata;
    unique case (state_q)
      ST_CLEAR: begin
        ram_addr  = clr_addr_q;
        ram_wdata = '0;
        ram_be    = '1;
        if (!CLEAR_ON_RESET) begin
          state_d = ST_READY;
        end else begin
          ram_we = 1'b1;
          if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
          else                         clr_addr_d = clr_addr_q + MEM_AW'(1);
        end
      end
      ST_READY: begin
        waitrequest = 1'b0;
        init_done   = 1'b1;
        ram_we      = wr_acc & in_range;
        ram_be      = byteenable;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  avmm_onchip_ram_core #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .MEM_AW         (MEM_AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .INIT_FILE      (INIT_FILE)
  ) u_core (
    .clk   (clk),
    .clken (clken),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Out-of-range reads return zero with normal timing.
  assign data1 = rng1_q ? ram_rdata : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic              rd2_q, rd2_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    always_comb begin
      rd2_d   = rd1_q;
      data2_d = data1;
    end
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rd2_q   <= 1'b0;
        data2_q <= '0;
      end else if (clken) begin
        rd2_q   <= rd2_d;
        data2_q <= data2_d;
      end
    end
    assign out_valid = rd2_q;
    assign out_data  = data2_q;
  end else begin : g_lat1
    assign out_valid = rd1_q;
    assign out_data  = data1;
  end

  always_comb begin
    rd1_d         = rd_acc;
    rng1_d        = in_range;
    readdatavalid = out_valid & clken;
    readdata      = readdatavalid ? out_data : rdata_hold_q;
    rdata_hold_d  = readdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      rd1_q        <= 1'b0;
      rng1_q       <= 1'b0;
      rdata_hold_q <= '0;
    end else if (clken) begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      rd1_q        <= rd1_d;
      rng1_q       <= rng1_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

endmodule

// File: tb/tb_avmm_onchip_ram.sv
// Scoreboard bench: a small-depth latency-1 RAM and a full-depth latency-2 RAM share one bus.
module tb_avmm_onchip_ram;

  localparam int N_DUT = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [11:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;

  logic [31:0] rdata [N_DUT];
  logic        rvalid [N_DUT];
  logic        wreq [N_DUT];
  logic        idone [N_DUT];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [N_DUT][4096];
  exp_t        sb [N_DUT][$];
  logic [31:0] hold_exp [N_DUT];
  bit          ready_s [N_DUT];
  int          en_cnt = 0;
  bit          mon_on = 1'b0;

  avmm_onchip_ram #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) u_small (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdata[0]), .readdatavalid(rvalid[0]),
    .waitrequest(wreq[0]), .init_done(idone[0])
  );

  avmm_onchip_ram #(
    .DATA_W(32), .DEPTH(4093), .ADDR_W(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) u_big (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdata[1]), .readdatavalid(rvalid[1]),
    .waitrequest(wreq[1]), .init_done(idone[1])
  );

  function automatic int dep_of(input int d);
    return (d == 0) ? 16 : 4093;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: memory contents and expected read responses per DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int d = 0; d < N_DUT; d++) begin
          sb[d].delete();
          hold_exp[d] = 32'h0;
          for (int a = 0; a < 4096; a++) mdl[d][a] = 32'h0;
        end
      end else if (clken) begin
        en_cnt++;
        for (int d = 0; d < N_DUT; d++) begin
          if (chipselect && (read || write) && ready_s[d]) begin
            if (write) begin
              if (int'(address) < dep_of(d))
                for (int i = 0; i < 4; i++)
                  if (byteenable[i]) mdl[d][address][i*8 +: 8] = writedata[i*8 +: 8];
            end else begin
              e.data = (int'(address) < dep_of(d)) ? mdl[d][address] : 32'h0;
              e.due  = en_cnt + lat_of(d) - 1;
              sb[d].push_back(e);
            end
          end
        end
      end
    end
  end

  // Monitor: compares every presented response and the held readdata.
  initial begin
    bit   exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < N_DUT; d++) begin
        ready_s[d] = !wreq[d];
        if (mon_on) begin
          exp_v = (sb[d].size() > 0) && (sb[d][0].due == en_cnt) && (clken == 1'b1);
          if (exp_v || rvalid[d]) begin
            if (exp_v) begin
              e = sb[d].pop_front();
              hold_exp[d] = e.data;
            end
            check($sformatf("readdatavalid_dut%0d", d), 32'(rvalid[d]), 32'(exp_v));
            if (exp_v && rvalid[d])
              check($sformatf("readdata_dut%0d", d), rdata[d], e.data);
          end else begin
            check($sformatf("readdata_hold_dut%0d", d), rdata[d], hold_exp[d]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [11:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    chipselect = 1'b1;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = wd;
    byteenable = be;
    tick();
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic measure_clear();
    int cnt;
    bit all_wait;
    cnt = 0;
    all_wait = 1'b1;
    forever begin
      @(negedge clk);
      if (idone[0] || cnt > 64) break;
      cnt++;
      all_wait &= wreq[0];
    end
    check("clear_cycles", cnt, 16);
    check("waitrequest_in_clear", 32'(all_wait), 1);
    check("waitrequest_ready", 32'(wreq[0]), 0);
    tick();
  endtask

  task automatic wait_big();
    int cnt;
    cnt = 0;
    while (!idone[1] && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("big_init_done", 32'(idone[1]), 1);
    tick();
  endtask

  initial begin
    int op;
    reset_n    = 1'b0;
    clken      = 1'b1;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    idle();
    repeat (3) tick();
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("reset_valid_dut%0d", d), 32'(rvalid[d]), 0);
      check($sformatf("reset_rdata_dut%0d", d), rdata[d], 0);
      check($sformatf("reset_waitreq_dut%0d", d), 32'(wreq[d]), 1);
      check($sformatf("reset_init_done_dut%0d", d), 32'(idone[d]), 0);
    end
    mon_on = 1'b1;

    reset_n = 1'b1;
    measure_clear();
    wait_big();
    for (int a = 0; a < 16; a++) bus(1'b1, 1'b0, 12'(a), 32'h0, 4'h0);
    drain(4);

    // Dirty the memory, reset with a read in flight, then reset again mid-clear.
    for (int a = 0; a < 16; a++) bus(1'b0, 1'b1, 12'(a), $urandom, 4'hF);
    bus(1'b1, 1'b0, 12'd7, 32'h0, 4'h0);
    reset_n = 1'b0;
    idle();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    measure_clear();
    wait_big();
    for (int a = 0; a < 16; a++) bus(1'b1, 1'b0, 12'(a), 32'h0, 4'h0);
    drain(4);

    // Byte lanes and read-after-write.
    bus(1'b0, 1'b1, 12'd5, 32'hDEADBEEF, 4'b1111);
    bus(1'b0, 1'b1, 12'd5, 32'h00AA0000, 4'b0100);
    bus(1'b1, 1'b0, 12'd5, 32'h0, 4'h0);
    bus(1'b0, 1'b1, 12'd6, 32'hCAFEF00D, 4'b0000);
    bus(1'b1, 1'b0, 12'd6, 32'h0, 4'h0);
    drain(4);

    // Out-of-range addresses.
    bus(1'b0, 1'b1, 12'd4092, 32'hA5A50001, 4'hF);
    bus(1'b0, 1'b1, 12'd4095, 32'h12345678, 4'hF);
    bus(1'b1, 1'b0, 12'd4095, 32'h0, 4'h0);
    bus(1'b1, 1'b0, 12'd4092, 32'h0, 4'h0);
    bus(1'b1, 1'b0, 12'd15, 32'h0, 4'h0);
    drain(4);

    // Burst with a clock-enable pause.
    for (int a = 0; a < 4; a++) bus(1'b0, 1'b1, 12'(a), 32'h10 + 32'(a), 4'hF);
    bus(1'b1, 1'b0, 12'd0, 32'h0, 4'h0);
    bus(1'b1, 1'b0, 12'd1, 32'h0, 4'h0);
    clken = 1'b0;
    bus(1'b1, 1'b0, 12'd2, 32'h0, 4'h0);
    bus(1'b1, 1'b0, 12'd2, 32'h0, 4'h0);
    clken = 1'b1;
    bus(1'b1, 1'b0, 12'd2, 32'h0, 4'h0);
    bus(1'b1, 1'b0, 12'd3, 32'h0, 4'h0);
    drain(4);

    // Read and write together act as a write.
    bus(1'b1, 1'b1, 12'd2, 32'h55, 4'hF);
    drain(3);
    bus(1'b1, 1'b0, 12'd2, 32'h0, 4'h0);
    drain(4);

    for (int i = 0; i < 400; i++) begin
      op         = int'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 5) != 0);
      read       = (op == 0 || op == 2);
      write      = (op == 1 || op == 2);
      address    = ($urandom_range(0, 7) == 0) ? 12'(4080 + $urandom_range(0, 15))
                                                : 12'($urandom_range(0, 19));
      writedata  = $urandom;
      byteenable = 4'($urandom);
      clken      = ($urandom_range(0, 7) != 0);
      tick();
    end
    clken = 1'b1;
    drain(10);

    for (int d = 0; d < N_DUT; d++)
      check($sformatf("responses_outstanding_dut%0d", d), sb[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
